// File: rtl/sdarb_sched_if.sv
// Bundle between the channel descriptor logic / SDRAM sequencer and the
// sdarb_sched command scheduler.
//   master : requester + sequencer side (drives en, req, descriptors, next)
//   slave  : scheduler side (drives xfer/refr, granted descriptor, ack, busy,
//            refr_pend)
// Signals:
//   en              grant enable
//   req[3:0]        per-channel transfer request (level)
//   sa0..sa3        per-channel block start address [24:3]
//   wnr_i, mode_i   per-channel direction / mode bits
//   param0..param3  per-channel parameter
//   next            sequencer ready for a new command
//   xfer, refr      one-cycle command start pulses
//   sa, chsel, wnr, mode, param  granted descriptor
//   ack[3:0]        one-hot one-cycle grant pulse
//   busy            command outstanding at the sequencer
//   refr_pend       pending refresh count
interface sdarb_sched_if;
  localparam int unsigned NCH     = 4;
  localparam int unsigned SA_W    = 22;
  localparam int unsigned PARAM_W = 6;
  localparam int unsigned CH_W    = 2;
  localparam int unsigned PEND_W  = 3;

  logic               en;
  logic [NCH-1:0]     req;
  logic [SA_W-1:0]    sa0;
  logic [SA_W-1:0]    sa1;
  logic [SA_W-1:0]    sa2;
  logic [SA_W-1:0]    sa3;
  logic [NCH-1:0]     wnr_i;
  logic [NCH-1:0]     mode_i;
  logic [PARAM_W-1:0] param0;
  logic [PARAM_W-1:0] param1;
  logic [PARAM_W-1:0] param2;
  logic [PARAM_W-1:0] param3;
  logic               next;

  logic               xfer;
  logic               refr;
  logic [SA_W-1:0]    sa;
  logic [CH_W-1:0]    chsel;
  logic               wnr;
  logic               mode;
  logic [PARAM_W-1:0] param;
  logic [NCH-1:0]     ack;
  logic               busy;
  logic [PEND_W-1:0]  refr_pend;

  modport master (
    output en, req, sa0, sa1, sa2, sa3, wnr_i, mode_i,
           param0, param1, param2, param3, next,
    input  xfer, refr, sa, chsel, wnr, mode, param, ack, busy, refr_pend
  );

  modport slave (
    input  en, req, sa0, sa1, sa2, sa3, wnr_i, mode_i,
           param0, param1, param2, param3, next,
    output xfer, refr, sa, chsel, wnr, mode, param, ack, busy, refr_pend
  );
endinterface

// File: rtl/sdarb_sched.sv
// SDRAM block-transfer command scheduler. Arbitrates four channel requesters
// and periodic auto-refresh onto one xfer/refr command stream, and holds the
// granted descriptor stable until the sequencer reports "next".
// All flops update on the falling edge of clk0; rst is asynchronous, active high.
// Ports:
//   clk0  global clock (falling-edge domain)
//   rst   asynchronous active-high reset
//   bus   sdarb_sched_if.slave (requests, descriptors, next in; commands,
//         granted descriptor, ack, busy, refr_pend out)
// Parameters:
//   REFR_PERIOD  clk0 cycles between refresh requests (16..4095)
//   REFR_URGENT  pending-refresh count at which refresh pre-empts channels (1..7)
// Optional feature macro SDARB_CH0_PRIO_EN: channel 0 gets fixed priority above
// a round-robin group of channels 1..3 (urgent refresh still wins); channel-0
// grants leave the round-robin pointer untouched. Undefined: plain four-way
// round-robin.
module sdarb_sched #(
  parameter int unsigned REFR_PERIOD = 780,
  parameter int unsigned REFR_URGENT = 4
) (
  input logic         clk0,
  input logic         rst,
  sdarb_sched_if.slave bus
);

  localparam int unsigned NCH     = 4;
  localparam int unsigned SA_W    = 22;
  localparam int unsigned PARAM_W = 6;
  localparam int unsigned CH_W    = 2;
  localparam int unsigned PEND_W  = 3;
  localparam int unsigned CNT_W   = 12;

  localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(REFR_PERIOD - 1);
  localparam logic [PEND_W-1:0] PEND_URG   = PEND_W'(REFR_URGENT);
  localparam logic [PEND_W-1:0] PEND_MAX   = PEND_W'(7);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t              state;
  logic [CH_W-1:0]     ptr;
  logic [CNT_W-1:0]    rcnt;
  logic [PEND_W-1:0]   pend;

  logic                xfer_q;
  logic                refr_q;
  logic [SA_W-1:0]     sa_q;
  logic [CH_W-1:0]     chsel_q;
  logic                wnr_q;
  logic                mode_q;
  logic [PARAM_W-1:0]  param_q;
  logic [NCH-1:0]      ack_q;
  logic                busy_q;

  logic                pick_vld_c;
  logic [CH_W-1:0]     pick_ch_c;
  logic [SA_W-1:0]     sel_sa_c;
  logic [PARAM_W-1:0]  sel_param_c;
  logic                sel_wnr_c;
  logic                sel_mode_c;
  logic                tick_c;
  logic                urgent_c;
  logic                do_xfer_c;
  logic                do_refr_c;

  // Channel selection: first requester after the pointer, wrapping.
  always_comb begin
    pick_vld_c = 1'b0;
    pick_ch_c  = '0;
`ifdef SDARB_CH0_PRIO_EN
    if (bus.req[0]) begin
      pick_vld_c = 1'b1;
      pick_ch_c  = '0;
    end else begin
      for (int i = 1; i <= NCH; i++) begin
        if (!pick_vld_c && ((ptr + CH_W'(i)) != '0) && bus.req[ptr + CH_W'(i)]) begin
          pick_vld_c = 1'b1;
          pick_ch_c  = ptr + CH_W'(i);
        end
      end
    end
`else
    for (int i = 1; i <= NCH; i++) begin
      if (!pick_vld_c && bus.req[ptr + CH_W'(i)]) begin
        pick_vld_c = 1'b1;
        pick_ch_c  = ptr + CH_W'(i);
      end
    end
`endif
  end

  // Descriptor of the selected channel.
  always_comb begin
    sel_sa_c    = bus.sa0;
    sel_param_c = bus.param0;
    case (pick_ch_c)
      2'd1: begin
        sel_sa_c    = bus.sa1;
        sel_param_c = bus.param1;
      end
      2'd2: begin
        sel_sa_c    = bus.sa2;
        sel_param_c = bus.param2;
      end
      2'd3: begin
        sel_sa_c    = bus.sa3;
        sel_param_c = bus.param3;
      end
      default: ;
    endcase
    sel_wnr_c  = bus.wnr_i[pick_ch_c];
    sel_mode_c = bus.mode_i[pick_ch_c];
  end

  // Arbitration decision for this edge; only meaningful in IDLE with en high.
  always_comb begin
    tick_c    = (rcnt == '0);
    urgent_c  = (pend >= PEND_URG);
    do_xfer_c = 1'b0;
    do_refr_c = 1'b0;
    if ((state == IDLE) && bus.en) begin
      if (urgent_c) begin
        do_refr_c = 1'b1;
      end else if (pick_vld_c) begin
        do_xfer_c = 1'b1;
      end else if (pend != '0) begin
        do_refr_c = 1'b1;
      end
    end
  end

  // Refresh timer, pending count, FSM and registered outputs.
  always_ff @(negedge clk0 or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= CH_W'(3);
      rcnt    <= CNT_RELOAD;
      pend    <= '0;
      xfer_q  <= 1'b0;
      refr_q  <= 1'b0;
      sa_q    <= '0;
      chsel_q <= '0;
      wnr_q   <= 1'b0;
      mode_q  <= 1'b0;
      param_q <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      rcnt <= tick_c ? CNT_RELOAD : rcnt - CNT_W'(1);

      // A tick and an issue on the same edge cancel out.
      if (tick_c && !do_refr_c) begin
        if (pend != PEND_MAX) pend <= pend + PEND_W'(1);
      end else if (do_refr_c && !tick_c) begin
        pend <= pend - PEND_W'(1);
      end

      xfer_q <= 1'b0;
      refr_q <= 1'b0;
      ack_q  <= '0;

      case (state)
        IDLE: begin
          if (do_xfer_c) begin
            xfer_q  <= 1'b1;
            ack_q   <= NCH'(1) << pick_ch_c;
            chsel_q <= pick_ch_c;
            sa_q    <= sel_sa_c;
            wnr_q   <= sel_wnr_c;
            mode_q  <= sel_mode_c;
            param_q <= sel_param_c;
`ifdef SDARB_CH0_PRIO_EN
            if (pick_ch_c != '0) ptr <= pick_ch_c;
`else
            ptr     <= pick_ch_c;
`endif
            busy_q  <= 1'b1;
            state   <= BUSY;
          end else if (do_refr_c) begin
            refr_q <= 1'b1;
            busy_q <= 1'b1;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (bus.next) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.xfer      = xfer_q;
  assign bus.refr      = refr_q;
  assign bus.sa        = sa_q;
  assign bus.chsel     = chsel_q;
  assign bus.wnr       = wnr_q;
  assign bus.mode      = mode_q;
  assign bus.param     = param_q;
  assign bus.ack       = ack_q;
  assign bus.busy      = busy_q;
  assign bus.refr_pend = pend;

endmodule
